// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - ARM MEM/WB stage: req/ack data-memory access, pipeline freeze, MEM/WB register
// Optional forwarding outputs enabled by defining MEMWB_FWD_EN.
module mem_wb_stage #(
    parameter int          ADDR_W   = 16,
    parameter logic [31:0] MEM_BASE = 32'd1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              WB_EN_in,
    input  logic              MEM_R_EN,
    input  logic              MEM_W_EN,
    input  logic [31:0]       ALU_Res,
    input  logic [31:0]       Val_Rm,
    input  logic [3:0]        Dest_in,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack,
    output logic              freeze,
    output logic              writeBackEn,
    output logic [3:0]        Dest_wb,
    output logic [31:0]       Result_WB
`ifdef MEMWB_FWD_EN
    ,
    output logic              fwd_en_mem,
    output logic [3:0]        fwd_dest_mem,
    output logic [31:0]       fwd_val_mem
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] load_data;
    logic        mem_op;
    logic        is_load;

    assign mem_op  = MEM_R_EN | MEM_W_EN;
    // A combined read+write request behaves as a store.
    assign is_load = MEM_R_EN & ~MEM_W_EN;
    assign freeze  = ((state == IDLE) & mem_op) | (state == ACCESS);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            load_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_op) begin
                        state     <= ACCESS;
                        mem_req   <= 1'b1;
                        mem_we    <= MEM_W_EN;
                        mem_addr  <= ADDR_W'((ALU_Res - MEM_BASE) >> 2);
                        mem_wdata <= Val_Rm;
                    end
                end
                ACCESS: begin
                    if (mem_ack) begin
                        state     <= DONE;
                        mem_req   <= 1'b0;
                        load_data <= mem_rdata;
                    end
                end
                // EX/MEM is still showing the finished op here; never relaunch it.
                DONE: state <= IDLE;
                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            writeBackEn <= 1'b0;
            Dest_wb     <= 4'd0;
            Result_WB   <= 32'd0;
        end else if (freeze) begin
            writeBackEn <= 1'b0;
        end else begin
            writeBackEn <= WB_EN_in;
            Dest_wb     <= Dest_in;
            Result_WB   <= is_load ? load_data : ALU_Res;
        end
    end

`ifdef MEMWB_FWD_EN
    assign fwd_en_mem   = WB_EN_in & ~MEM_R_EN & ~freeze;
    assign fwd_dest_mem = Dest_in;
    assign fwd_val_mem  = ALU_Res;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - self-checking bench for mem_wb_stage with a transaction-level reference model
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        WB_EN_in = 1'b0, MEM_R_EN = 1'b0, MEM_W_EN = 1'b0;
    logic [31:0] ALU_Res = '0, Val_Rm = '0;
    logic [3:0]  Dest_in = '0;
    logic        mem_req, mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic        freeze, writeBackEn;
    logic [3:0]  Dest_wb;
    logic [31:0] Result_WB;
`ifdef MEMWB_FWD_EN
    logic        fwd_en_mem;
    logic [3:0]  fwd_dest_mem;
    logic [31:0] fwd_val_mem;
`endif

    mem_wb_stage #(.ADDR_W(16), .MEM_BASE(32'd1024)) dut (
        .clk(clk), .rst(rst),
        .WB_EN_in(WB_EN_in), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN),
        .ALU_Res(ALU_Res), .Val_Rm(Val_Rm), .Dest_in(Dest_in),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .freeze(freeze),
        .writeBackEn(writeBackEn), .Dest_wb(Dest_wb), .Result_WB(Result_WB)
`ifdef MEMWB_FWD_EN
        ,
        .fwd_en_mem(fwd_en_mem), .fwd_dest_mem(fwd_dest_mem), .fwd_val_mem(fwd_val_mem)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference memory (updated from stimulus) and environment memory (updated from DUT outputs).
    logic [31:0] model_mem [logic [15:0]];
    logic [31:0] env_mem   [logic [15:0]];
    logic [3:0]  prev_dest = 4'd0;
    logic [31:0] prev_res  = 32'd0;

    function automatic logic [31:0] init_val(input logic [15:0] a);
        return 32'hA5A5_0000 ^ {16'h0, a};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one EX/MEM instruction, act as memory with 'lat' wait cycles, check every cycle.
    task automatic run_op(input logic wb, input logic r, input logic w, input logic [31:0] alu,
                          input logic [31:0] rm, input logic [3:0] dest, input int lat);
        logic        mem;
        logic [31:0] diff;
        logic [15:0] a;
        logic [31:0] exp_res;
        logic [15:0] dut_a;
        bit          done;
        int          c;
        mem     = r | w;
        diff    = alu - 32'd1024;
        a       = diff[17:2];
        exp_res = alu;
        if (r && !w) exp_res = model_mem.exists(a) ? model_mem[a] : init_val(a);
        if (w) model_mem[a] = rm;
        WB_EN_in = wb; MEM_R_EN = r; MEM_W_EN = w;
        ALU_Res = alu; Val_Rm = rm; Dest_in = dest;
        done = 0;
        c = 0;
        while (!done && c < 50) begin
            @(negedge clk);
            check("freeze", {31'd0, freeze}, {31'd0, mem && c <= lat});
            check("mem_req", {31'd0, mem_req}, {31'd0, mem && c >= 1 && c <= lat});
`ifdef MEMWB_FWD_EN
            if (c == 0) begin
                check("fwd_en_mem", {31'd0, fwd_en_mem}, {31'd0, wb && !r && !mem});
                check("fwd_dest_mem", {28'd0, fwd_dest_mem}, {28'd0, dest});
                check("fwd_val_mem", fwd_val_mem, alu);
            end
`endif
            if (c >= 1) begin
                check("bubble_wb_en", {31'd0, writeBackEn}, 32'd0);
                check("hold_dest", {28'd0, Dest_wb}, {28'd0, prev_dest});
                check("hold_result", Result_WB, prev_res);
            end
            if (mem_req) begin
                check("mem_addr", {16'd0, mem_addr}, {16'd0, a});
                check("mem_we", {31'd0, mem_we}, {31'd0, w});
                if (w) check("mem_wdata", mem_wdata, rm);
            end
            mem_ack   = 1'b0;
            mem_rdata = $urandom;
            if (mem && c == lat && mem_req) begin
                dut_a = mem_addr;
                if (mem_we) env_mem[dut_a] = mem_wdata;
                else mem_rdata = env_mem.exists(dut_a) ? env_mem[dut_a] : init_val(dut_a);
                mem_ack = 1'b1;
            end else if (mem && (c == 0 || c == lat + 1)) begin
                mem_ack = 1'($urandom % 2);
            end
            if (!freeze) begin
                @(posedge clk);
                #1;
                mem_ack = 1'b0;
                check("latency", c, mem ? lat + 1 : 0);
                check("writeBackEn", {31'd0, writeBackEn}, {31'd0, wb});
                check("Dest_wb", {28'd0, Dest_wb}, {28'd0, dest});
                check("Result_WB", Result_WB, exp_res);
                prev_dest = dest;
                prev_res  = exp_res;
                done = 1;
            end else begin
                @(posedge clk);
                #1;
                mem_ack = 1'b0;
                c++;
            end
        end
        if (!done) check("timeout", c, mem ? lat + 1 : 0);
    endtask

    initial begin
        env_mem[16'd2]   = 32'hDEAD_BEEF;
        model_mem[16'd2] = 32'hDEAD_BEEF;
        repeat (2) @(posedge clk);
        #1;
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_wb_en", {31'd0, writeBackEn}, 32'd0);
        check("rst_result", Result_WB, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("idle_freeze", {31'd0, freeze}, 32'd0);
        check("idle_mem_addr", {16'd0, mem_addr}, 32'd0);

        run_op(1'b1, 1'b0, 1'b0, 32'h0000_00AB, 32'h0, 4'd3, 0);
        run_op(1'b1, 1'b1, 1'b0, 32'd1032, 32'h0, 4'd5, 1);
        check("ldr_deadbeef", Result_WB, 32'hDEAD_BEEF);
        run_op(1'b0, 1'b0, 1'b1, 32'd1036, 32'h1234_5678, 4'd1, 4);
        run_op(1'b1, 1'b1, 1'b0, 32'd1036, 32'h0, 4'd6, 1);
        run_op(1'b1, 1'b1, 1'b0, 32'd1032, 32'h0, 4'd7, 2);
        run_op(1'b1, 1'b1, 1'b1, 32'd1044, 32'hCAFE_F00D, 4'd8, 1);
        run_op(1'b1, 1'b1, 1'b0, 32'd1044, 32'h0, 4'd9, 3);

        // Reset in the middle of an access, then a stray ack.
        WB_EN_in = 1'b1; MEM_R_EN = 1'b1; MEM_W_EN = 1'b0;
        ALU_Res = 32'd1048; Dest_in = 4'd4;
        repeat (2) @(negedge clk);
        check("pre_rst_req", {31'd0, mem_req}, 32'd1);
        #1 rst = 1'b1;
        #1;
        check("arst_mem_req", {31'd0, mem_req}, 32'd0);
        check("arst_wb_en", {31'd0, writeBackEn}, 32'd0);
        check("arst_result", Result_WB, 32'd0);
        check("arst_dest", {28'd0, Dest_wb}, 32'd0);
        MEM_R_EN = 1'b0; ALU_Res = 32'h0000_0055; Dest_in = 4'd9;
        #1 rst = 1'b0;
        #1;
        check("post_rst_freeze", {31'd0, freeze}, 32'd0);
        mem_ack = 1'b1;
        mem_rdata = 32'hBAD0_BAD0;
        @(posedge clk);
        #1;
        mem_ack = 1'b0;
        check("post_rst_req", {31'd0, mem_req}, 32'd0);
        check("post_rst_wb_en", {31'd0, writeBackEn}, 32'd1);
        check("post_rst_result", Result_WB, 32'h0000_0055);
        prev_dest = 4'd9;
        prev_res  = 32'h0000_0055;

        for (int i = 0; i < 60; i++) begin
            int          kind;
            logic        r, w;
            logic [31:0] alu;
            kind = int'($urandom % 7);
            r = (kind == 1 || kind == 2 || kind == 6);
            w = (kind == 3 || kind == 4 || kind == 6);
            alu = 32'd1024 + ($urandom % 16) * 4 + ($urandom % 4);
            if ($urandom % 8 == 0) alu = $urandom;
            run_op(1'($urandom % 2), r, w, alu, $urandom, 4'($urandom), int'($urandom_range(1, 5)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
